mem_arbiter: RTL

- Shares one 32-bit memory port between instruction fetch (IF) and load/store (LS) in the RV32 pipeline core.
- Single outstanding transaction. Requests are latched on grant, then held on the memory port until acknowledged.
- The response is routed back to the owning requester.
- Sits in npc between the datapath and the memory model. Replaces the separate instruction and data memory instances with one arbitrated port.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified IF/LS memory port arbiter: FSM states,
// transaction owner and the empty byte mask.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam logic [3:0] MEM_MASK_NONE = 4'h0;
  localparam int         CNT_W         = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester (IF, LS) and memory-port signals of mem_arbiter. The master view
// belongs to the arbiter; the slave view belongs to the surrounding core/memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [3:0]        ls_wmask;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              bus_err;

  modport master (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
    input  mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output bus_err
  );

  modport slave (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
    output mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  bus_err
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and load/store. Default build gives LS fixed
// priority; defining RR_ARB_EN alternates ties away from the last owner.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   if_req,
  input  logic   ls_req,
  input  logic   idle,
  input  owner_t last_owner,
  output logic   if_gnt,
  output logic   ls_gnt
);

  logic ls_win;

`ifdef RR_ARB_EN
  assign ls_win = ls_req & (~if_req | (last_owner == OWN_IF));
`else
  logic unused_last_owner;
  assign unused_last_owner = (last_owner == OWN_LS);
  assign ls_win            = ls_req;
`endif

  assign ls_gnt = idle & ls_win;
  assign if_gnt = idle & if_req & ~ls_win;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store with a single outstanding
// transaction and a WAIT timeout. Optional round-robin ties via RR_ARB_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  localparam logic [CNT_W:0] TIMEOUT_CNT = TIMEOUT[CNT_W:0];

  state_t            state;
  state_t            state_next;
  owner_t            owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        mask_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W:0]    cnt_inc;
  logic              err_q;
  logic              idle;
  logic              in_wait;
  logic              in_resp;
  logic              timeout;
  logic              pick_if;
  logic              pick_ls;

  // The owner register doubles as the last-owner flag: it only changes on a grant.
  assign idle = (state == IDLE) & rst;

  mem_arb_pick u_pick (
    .if_req     (bus.if_req),
    .ls_req     (bus.ls_req),
    .idle       (idle),
    .last_owner (owner),
    .if_gnt     (pick_if),
    .ls_gnt     (pick_ls)
  );

  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign timeout = (cnt_inc == TIMEOUT_CNT);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_if | pick_ls) state_next = WAIT;
      WAIT:    if (bus.mem_ack || timeout) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // An ack on the final WAIT cycle wins over the timeout abort.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner   <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= MEM_MASK_NONE;
      rdata_q <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_ls) begin
            owner   <= OWN_LS;
            we_q    <= bus.ls_we;
            addr_q  <= bus.ls_addr;
            wdata_q <= bus.ls_wdata;
            mask_q  <= bus.ls_we ? bus.ls_wmask : MEM_MASK_NONE;
          end else if (pick_if) begin
            owner   <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= bus.if_addr;
            wdata_q <= '0;
            mask_q  <= MEM_MASK_NONE;
          end
        end
        WAIT: begin
          cnt <= cnt_inc[CNT_W-1:0];
          if (bus.mem_ack) begin
            rdata_q <= we_q ? '0 : bus.mem_rdata;
          end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        RESP: begin
          cnt   <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_wait = (state == WAIT);
  assign in_resp = (state == RESP);

  assign bus.if_gnt    = pick_if;
  assign bus.ls_gnt    = pick_ls;
  assign bus.mem_req   = in_wait;
  assign bus.mem_we    = in_wait & we_q;
  assign bus.mem_addr  = in_wait ? addr_q  : '0;
  assign bus.mem_wdata = in_wait ? wdata_q : '0;
  assign bus.mem_wmask = in_wait ? mask_q  : MEM_MASK_NONE;

  assign bus.if_rvalid = in_resp & (owner == OWN_IF);
  assign bus.ls_rvalid = in_resp & (owner == OWN_LS);
  assign bus.if_rdata  = bus.if_rvalid ? rdata_q : '0;
  assign bus.ls_rdata  = bus.ls_rvalid ? rdata_q : '0;
  assign bus.bus_err   = in_resp & err_q;

endmodule
